stack_machine_core: RTL and testbench

STACK_MACHINE_CORE -- requirements
Module: stack_machine_core

---
 rtl/stack_machine_pkg.sv | 42 ++++
 rtl/stack_machine_core_lifo.sv | 43 ++++
 rtl/stack_machine_core.sv | 150 +++++++++++++++
 tb/tb_stack_machine_core.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_machine_pkg.sv
// Shared types for the stack machine: opcode and FSM state enums plus the ALU result function.
package stack_machine_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_NOT  = 3'd3,
        OP_PUSH = 3'd4,
        OP_POP  = 3'd5,
        OP_JMP  = 3'd6,
        OP_JZ   = 3'd7
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_POPY,
        S_POPX,
        S_EXEC,
        S_PUSHM,
        S_POPM,
        S_TRAP
    } state_e;

    localparam int unsigned ALU_W = 32;

    // Operands arrive zero-extended; callers truncate the result to their data width.
    function automatic logic [ALU_W-1:0] alu_result(input opcode_e op,
                                                    input logic [ALU_W-1:0] x,
                                                    input logic [ALU_W-1:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_NOT:  return ~x;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/stack_machine_core_lifo.sv
// LIFO stack for the stack machine; pushes when full and pops when empty are ignored.
module stack_lifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        d_in,
    output logic [DATA_W-1:0]        tos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top_idx;

    assign full    = (depth == (PTR_W+1)'(DEPTH));
    assign empty   = (depth == '0);
    assign top_idx = PTR_W'(depth - (PTR_W+1)'(1));
    assign tos     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[depth[PTR_W-1:0]] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            depth <= depth - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/stack_machine_core.sv
// Multi-cycle stack machine core with unified instruction/data memory port.
// Optional feature: define STACK_MACHINE_TRAP_EN to trap on stack overflow/underflow.
module stack_machine_core
    import stack_machine_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    input  logic [ADDR_W+2:0]              mem_rdata,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [ADDR_W+2:0]              mem_wdata,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W+2:0]              tos,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           busy,
    output logic                           trap
);

    localparam int unsigned DATA_W = ADDR_W + 3;

    state_e            state, state_nxt;
    logic [DATA_W-1:0] ir, x, y;
    logic [DATA_W-1:0] push_data, alu_out;
    logic              push_req, pop_req, we_req;
    logic              push, pop, full, empty;
    opcode_e           op;
    logic [ADDR_W-1:0] ir_addr;

    assign op      = opcode_e'(ir[DATA_W-1 -: 3]);
    assign ir_addr = ir[ADDR_W-1:0];
    assign alu_out = DATA_W'(alu_result(op, ALU_W'(x), ALU_W'(y)));

    stack_lifo #(
        .DATA_W (DATA_W),
        .DEPTH  (STACK_DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .d_in  (push_data),
        .tos   (tos),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        we_req    = 1'b0;
        push_data = alu_out;
        mem_addr  = pc;
        mem_wdata = tos;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = run ? S_DECODE : S_IDLE;
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND: state_nxt = S_POPY;
                    OP_NOT:                 state_nxt = S_POPX;
                    OP_PUSH:                state_nxt = S_PUSHM;
                    OP_POP:                 state_nxt = S_POPM;
                    default:                state_nxt = S_FETCH;
                endcase
            end
            S_POPY: begin
                pop_req   = 1'b1;
                state_nxt = S_POPX;
            end
            S_POPX: begin
                pop_req   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                push_req  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_PUSHM: begin
                mem_addr  = ir_addr;
                push_data = mem_rdata;
                push_req  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_POPM: begin
                mem_addr  = ir_addr;
                pop_req   = 1'b1;
                we_req    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase

        push   = push_req && !full;
        pop    = pop_req && !empty;
        mem_we = we_req;
`ifdef STACK_MACHINE_TRAP_EN
        // A faulting stack access is dropped entirely, including the store of a POP.
        if ((push_req && full) || (pop_req && empty)) begin
            push      = 1'b0;
            pop       = 1'b0;
            mem_we    = 1'b0;
            state_nxt = S_TRAP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: begin
                    if (run) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    if (op == OP_JMP || (op == OP_JZ && tos == '0)) begin
                        pc <= ir_addr;
                    end
                end
                S_POPY:  y <= tos;
                S_POPX:  x <= tos;
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE) && (state != S_TRAP);

`ifdef STACK_MACHINE_TRAP_EN
    assign trap = (state == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_stack_machine_core.sv
// Self-checking bench for stack_machine_core: directed scenarios plus random programs vs an ISA-level model.
module tb_stack_machine_core;

    localparam int MEM_N = 32;

    logic       clk = 1'b0;
    logic       rst, run, load;
    logic [7:0] mem_rdata, mem_wdata, tos;
    logic [4:0] mem_addr, pc, depth;
    logic       mem_we, busy, trap;

    logic [7:0] tmem  [MEM_N];
    logic [7:0] image [MEM_N];

    int checks = 0;
    int errors = 0;

    // Instruction-level reference model state
    logic [7:0] m_mem [MEM_N];
    logic [4:0] m_pc;
    logic [7:0] m_stk [$];
    bit         m_trap;

    stack_machine_core #(
        .ADDR_W      (5),
        .STACK_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .pc        (pc),
        .tos       (tos),
        .depth     (depth),
        .busy      (busy),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tmem[mem_addr];

    always @(posedge clk) begin
        if (load) tmem <= image;
        else if (mem_we) tmem[mem_addr] <= mem_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ins(input int op, input int a);
        logic [7:0] w;
        w = {3'(op), 5'(a)};
        return w;
    endfunction

    function automatic logic [7:0] m_tos();
        if (m_stk.size() == 0) return 8'h00;
        return m_stk[$];
    endfunction

    function automatic logic [7:0] m_pop();
        if (m_stk.size() == 0) begin
`ifdef STACK_MACHINE_TRAP_EN
            m_trap = 1'b1;
`endif
            return 8'h00;
        end
        return m_stk.pop_back();
    endfunction

    function automatic void m_push(input logic [7:0] v);
        if (m_stk.size() == 16) begin
`ifdef STACK_MACHINE_TRAP_EN
            m_trap = 1'b1;
`endif
        end else begin
            m_stk.push_back(v);
        end
    endfunction

    // Executes one instruction on the model; returns its cycle count
    task automatic model_step(output int lat);
        logic [7:0] ir, xv, yv;
        logic [2:0] op;
        logic [4:0] a;
        ir   = m_mem[m_pc];
        m_pc = m_pc + 5'd1;
        op   = ir[7:5];
        a    = ir[4:0];
        case (op)
            3'd0, 3'd1, 3'd2: begin
                lat = 5;
                yv  = m_pop();
                if (!m_trap) begin
                    xv = m_pop();
                    if (!m_trap) m_push(op == 3'd0 ? xv + yv : op == 3'd1 ? xv - yv : xv & yv);
                end
            end
            3'd3: begin
                lat = 4;
                xv  = m_pop();
                if (!m_trap) m_push(~xv);
            end
            3'd4: begin
                lat = 3;
                m_push(m_mem[a]);
            end
            3'd5: begin
                lat = 3;
                xv  = m_pop();
                if (!m_trap) m_mem[a] = xv;
            end
            3'd6: begin
                lat  = 2;
                m_pc = a;
            end
            default: begin
                lat = 2;
                if (m_tos() == 8'h00) m_pc = a;
            end
        endcase
    endtask

    task automatic clear_image();
        for (int i = 0; i < MEM_N; i++) image[i] = 8'h00;
    endtask

    // Holds reset while the memory image is loaded, then releases it
    task automatic apply_image();
        @(negedge clk);
        rst  = 1'b0;
        run  = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < MEM_N; i++) m_mem[i] = image[i];
        m_pc   = 5'd0;
        m_trap = 1'b0;
        m_stk.delete();
    endtask

    task automatic go();
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_image();
        image[0] = ins(4, 20);
        apply_image();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
        checks++; if (tos !== 8'h00) begin errors++; $display("FAIL reset_tos got %0h exp 0", tos); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %0b exp 0", trap); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    endtask

    task automatic test_sub_program();
        int         cyc;
        bit         found;
        logic [7:0] wd;
        logic [4:0] wa;
        clear_image();
        image[0]  = ins(4, 20);
        image[1]  = ins(4, 21);
        image[2]  = ins(1, 0);
        image[3]  = ins(5, 22);
        image[4]  = ins(6, 4);
        image[20] = 8'd9;
        image[21] = 8'd4;
        apply_image();
        go();
        found = 1'b0;
        wd    = 8'h00;
        wa    = 5'd0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (mem_we) begin
                found = 1'b1;
                wd    = mem_wdata;
                wa    = mem_addr;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found || cyc != 13) begin errors++; $display("FAIL sub_store_cycle got %0d exp 13", cyc); end
        checks++; if (wa !== 5'd22) begin errors++; $display("FAIL sub_store_addr got %0d exp 22", wa); end
        checks++; if (wd !== 8'd5) begin errors++; $display("FAIL sub_store_data got %0d exp 5", wd); end
        @(negedge clk);
        checks++; if (tmem[22] !== 8'd5) begin errors++; $display("FAIL sub_mem22 got %0d exp 5", tmem[22]); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL sub_depth got %0d exp 0", depth); end
    endtask

    task automatic test_not();
        clear_image();
        image[0]  = ins(4, 20);
        image[1]  = ins(3, 0);
        image[2]  = ins(6, 2);
        image[20] = 8'h0F;
        apply_image();
        go();
        repeat (3) @(negedge clk);
        checks++; if (tos !== 8'h0F) begin errors++; $display("FAIL not_pre_tos got %0h exp 0f", tos); end
        repeat (3) @(negedge clk);
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL not_exec_depth got %0d exp 0", depth); end
        @(negedge clk);
        checks++; if (tos !== 8'hF0) begin errors++; $display("FAIL not_tos got %0h exp f0", tos); end
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL not_depth got %0d exp 1", depth); end
        checks++; if (pc !== 5'd2) begin errors++; $display("FAIL not_pc got %0d exp 2", pc); end
    endtask

    task automatic test_jz();
        logic [7:0] vals [2];
        logic [4:0] exp_pc;
        vals[0] = 8'h00;
        vals[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            clear_image();
            image[0]  = ins(4, 20);
            image[1]  = ins(7, 7);
            image[2]  = ins(6, 2);
            image[7]  = ins(6, 7);
            image[20] = vals[k];
            apply_image();
            go();
            repeat (5) @(negedge clk);
            exp_pc = (k == 0) ? 5'd7 : 5'd2;
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jz_pc[%0d] got %0d exp %0d", k, pc, exp_pc); end
            checks++; if (depth !== 5'd1) begin errors++; $display("FAIL jz_depth[%0d] got %0d exp 1", k, depth); end
        end
        clear_image();
        image[0] = ins(7, 9);
        image[9] = ins(6, 9);
        apply_image();
        go();
        repeat (2) @(negedge clk);
        checks++; if (pc !== 5'd9) begin errors++; $display("FAIL jz_empty_pc got %0d exp 9", pc); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL jz_empty_depth got %0d exp 0", depth); end
    endtask

    task automatic test_wrap();
        clear_image();
        image[0]  = ins(6, 31);
        image[31] = ins(4, 20);
        image[20] = 8'h5A;
        apply_image();
        go();
        repeat (2) @(negedge clk);
        checks++; if (pc !== 5'd31) begin errors++; $display("FAIL wrap_pre_pc got %0d exp 31", pc); end
        @(negedge clk);
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL wrap_pc got %0d exp 0", pc); end
        repeat (2) @(negedge clk);
        checks++; if (tos !== 8'h5A || depth !== 5'd1) begin errors++; $display("FAIL wrap_push got tos %0h depth %0d exp 5a 1", tos, depth); end
    endtask

    task automatic test_overflow();
        clear_image();
        for (int i = 0; i < 17; i++) image[i] = ins(4, 24 + (i % 4));
        image[17] = ins(6, 17);
        for (int i = 0; i < 4; i++) image[24 + i] = 8'(8'h30 + i);
        apply_image();
        go();
        repeat (51) @(negedge clk);
        checks++; if (depth !== 5'd16) begin errors++; $display("FAIL ovf_depth got %0d exp 16", depth); end
        checks++; if (tos !== 8'h33) begin errors++; $display("FAIL ovf_tos got %0h exp 33", tos); end
`ifdef STACK_MACHINE_TRAP_EN
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL ovf_trap got %0b exp 1", trap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %0b exp 0", busy); end
        repeat (6) @(negedge clk);
        checks++; if (trap !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovf_sticky got trap %0b busy %0b exp 1 0", trap, busy); end
`else
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL ovf_trap got %0b exp 0", trap); end
        checks++; if (pc !== 5'd17) begin errors++; $display("FAIL ovf_pc got %0d exp 17", pc); end
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1 || depth !== 5'd16) begin errors++; $display("FAIL ovf_continue got busy %0b depth %0d exp 1 16", busy, depth); end
`endif
    endtask

    task automatic test_run_stop();
        clear_image();
        image[0]  = ins(4, 20);
        image[1]  = ins(4, 21);
        image[2]  = ins(0, 0);
        image[3]  = ins(6, 3);
        image[20] = 8'h70;
        image[21] = 8'h25;
        apply_image();
        go();
        repeat (10) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++; if (tos !== 8'h95 || depth !== 5'd1) begin errors++; $display("FAIL stop_result got tos %0h depth %0d exp 95 1", tos, depth); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %0b exp 0", busy); end
        checks++; if (pc !== 5'd3) begin errors++; $display("FAIL stop_pc got %0d exp 3", pc); end
        repeat (4) @(negedge clk);
        checks++; if (pc !== 5'd3 || busy !== 1'b0) begin errors++; $display("FAIL stop_hold got pc %0d busy %0b exp 3 0", pc, busy); end
    endtask

    task automatic test_reset_popm();
        clear_image();
        image[0]  = ins(4, 20);
        image[1]  = ins(5, 22);
        image[2]  = ins(6, 2);
        image[20] = 8'hA5;
        apply_image();
        go();
        repeat (5) @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL popm_we got %0b exp 1", mem_we); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_mem_we got %0b exp 0", mem_we); end
        checks++; if (pc !== 5'd0 || depth !== 5'd0 || tos !== 8'h00) begin errors++; $display("FAIL rstmid_state got pc %0d depth %0d tos %0h exp 0 0 0", pc, depth, tos); end
        checks++; if (busy !== 1'b0 || trap !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy %0b trap %0b exp 0 0", busy, trap); end
        @(negedge clk);
        checks++; if (tmem[22] !== 8'h00) begin errors++; $display("FAIL rstmid_no_store got %0h exp 0", tmem[22]); end
        rst = 1'b1;
    endtask

    task automatic test_random();
        int lat, diffs;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < MEM_N; i++) image[i] = 8'($urandom_range(0, 255));
            apply_image();
            go();
            for (int n = 0; n < 40; n++) begin
                model_step(lat);
                repeat (lat) @(negedge clk);
                checks++;
                if (pc !== m_pc || depth !== 5'(m_stk.size()) || tos !== m_tos()) begin
                    errors++;
                    $display("FAIL rand[%0d.%0d] got pc %0d depth %0d tos %0h exp %0d %0d %0h",
                             t, n, pc, depth, tos, m_pc, m_stk.size(), m_tos());
                    break;
                end
                if (m_trap) begin
                    checks++;
                    if (trap !== 1'b1 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_trap[%0d] got trap %0b busy %0b exp 1 0", t, trap, busy);
                    end
                    break;
                end
            end
            diffs = 0;
            for (int i = 0; i < MEM_N; i++) if (tmem[i] !== m_mem[i]) diffs++;
            checks++; if (diffs != 0) begin errors++; $display("FAIL rand_mem[%0d] got %0d differing words exp 0", t, diffs); end
        end
    endtask

    initial begin
        rst  = 1'b0;
        run  = 1'b0;
        load = 1'b0;
        test_reset();
        test_sub_program();
        test_not();
        test_jz();
        test_wrap();
        test_overflow();
        test_run_stop();
        test_reset_popm();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
